// File: rtl/feature_classifier_pkg.sv
// Shared constants, FSM state type and address decode helper for the feature classifier.
// The feature order matches the extractor's serial output order.
package feature_classifier_pkg;

    localparam int unsigned NF       = 10;
    localparam int unsigned IDX_W    = 4;
    localparam logic [3:0]  BIAS_IDX = 4'd15;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StCapture,
        StMac,
        StDone
    } fc_state_e;

    typedef enum int unsigned {
        FRms, FDiff, FStd, FDisp, FKurt, FSkew, FEntropy, FJerk, FPeaks, FMaxMag
    } feat_idx_e;

    // Class field must name an existing class; index is a weight slot or the bias slot.
    function automatic logic fc_addr_ok(logic [7:0] addr, int unsigned num_class);
        return (32'(addr[7:4]) < num_class) &&
               ((addr[3:0] < 4'(NF)) || (addr[3:0] == BIAS_IDX));
    endfunction

endpackage

// File: rtl/feature_classifier_if.sv
// Feature stream, weight write port and result handshake of the feature classifier.
// master drives stimulus/consumes results; slave is the classifier side.
interface feature_classifier_if #(
    parameter int unsigned N     = 24,
    parameter int unsigned WW    = 16,
    parameter int unsigned ACC_W = N + WW + 5
) ();

    logic signed [N-1:0]     f_in;
    logic                    f_finish;
    logic                    w_wr;
    logic [7:0]              w_addr;
    logic [N+WW-1:0]         w_data;
    logic                    w_busy;
    logic                    c_valid;
    logic                    c_ready;
    logic [2:0]              c_class;
    logic signed [ACC_W-1:0] c_score;

    modport master (
        output f_in, f_finish, w_wr, w_addr, w_data, c_ready,
        input  w_busy, c_valid, c_class, c_score
    );

    modport slave (
        input  f_in, f_finish, w_wr, w_addr, w_data, c_ready,
        output w_busy, c_valid, c_class, c_score
    );

endinterface

// File: rtl/feature_classifier_mac.sv
// Signed multiply-accumulate: one full-precision product per enabled cycle,
// bias preloaded instead of the running sum on the first product of a class.
module feature_classifier_mac #(
    parameter int unsigned N     = 24,
    parameter int unsigned WW    = 16,
    parameter int unsigned ACC_W = N + WW + 5
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    en_i,
    input  logic                    preload_i,
    input  logic signed [ACC_W-1:0] bias_i,
    input  logic signed [N-1:0]     feat_i,
    input  logic signed [WW-1:0]    weight_i,
    output logic signed [ACC_W-1:0] sum_o
);

    logic signed [N+WW-1:0]  prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_d, acc_q;

    always_comb begin
        prod     = feat_i * weight_i;
        prod_ext = {{(ACC_W - N - WW){prod[N+WW-1]}}, prod};
        sum_o    = (preload_i ? bias_i : acc_q) + prod_ext;
    end

    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = sum_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/feature_classifier.sv
// Captures a 10-word feature burst, scores every class as bias + sum(w*f) one product per
// cycle, and presents the argmax class and score on a valid/ready handshake.
module feature_classifier
    import feature_classifier_pkg::*;
#(
    parameter int unsigned N         = 24,
    parameter int unsigned WW        = 16,
    parameter int unsigned NUM_CLASS = 3,
    parameter int unsigned ACC_W     = N + WW + 5
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic                 start,
    feature_classifier_if.slave  bus
);

    localparam int unsigned CW = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;

    fc_state_e state_d, state_q;

    logic                    f_finish_q;
    logic [IDX_W-1:0]        cnt_d, cnt_q;
    logic [CW-1:0]           cls_d, cls_q;
    logic signed [N-1:0]     feat_d [NF];
    logic signed [N-1:0]     feat_q [NF];
    logic signed [WW-1:0]    w_d    [NUM_CLASS][NF];
    logic signed [WW-1:0]    w_q    [NUM_CLASS][NF];
    logic signed [ACC_W-1:0] bias_d [NUM_CLASS];
    logic signed [ACC_W-1:0] bias_q [NUM_CLASS];
    logic [2:0]              best_class_d, best_class_q;
    logic signed [ACC_W-1:0] best_score_d, best_score_q;
    logic                    c_valid_d, c_valid_q;

    logic                    w_busy, cap_en, mac_en;
    logic                    last_i, last_cls, wr_ok;
    logic [CW-1:0]           wr_cls;
    logic signed [ACC_W-1:0] mac_sum;

    assign last_i   = (cnt_q == 4'(NF - 1));
    assign last_cls = (32'(cls_q) == NUM_CLASS - 1);
    assign wr_cls   = bus.w_addr[CW+3:4];
    assign wr_ok    = bus.w_wr && (state_q != StMac) && fc_addr_ok(bus.w_addr, NUM_CLASS);

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // start low is a synchronous clear that overrides every state.
    always_comb begin
        state_d = state_q;
        if (!start) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:    if (bus.f_finish && !f_finish_q) state_d = StArm;
                StArm:     state_d = StCapture;
                StCapture: if (last_i) state_d = StMac;
                StMac:     if (last_i && last_cls) state_d = StDone;
                StDone:    if (c_valid_q && bus.c_ready) state_d = StIdle;
                default:   state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        w_busy = 1'b0;
        cap_en = 1'b0;
        mac_en = 1'b0;
        case (state_q)
            StCapture: cap_en = start;
            StMac: begin
                w_busy = 1'b1;
                mac_en = start;
            end
            default: ;
        endcase
    end

    feature_classifier_mac #(
        .N     (N),
        .WW    (WW),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk_i     (clk),
        .rst_ni    (nReset),
        .clear_i   (!start),
        .en_i      (mac_en),
        .preload_i (cnt_q == '0),
        .bias_i    (bias_q[cls_q]),
        .feat_i    (feat_q[cnt_q]),
        .weight_i  (w_q[cls_q][cnt_q]),
        .sum_o     (mac_sum)
    );

    always_comb begin
        feat_d       = feat_q;
        w_d          = w_q;
        bias_d       = bias_q;
        best_class_d = best_class_q;
        best_score_d = best_score_q;
        c_valid_d    = 1'b0;
        cnt_d        = '0;
        cls_d        = '0;

        if (wr_ok) begin
            if (bus.w_addr[3:0] == BIAS_IDX) begin
                bias_d[wr_cls] = {{(ACC_W - N - WW){bus.w_data[N+WW-1]}}, bus.w_data};
            end else begin
                w_d[wr_cls][bus.w_addr[3:0]] = bus.w_data[WW-1:0];
            end
        end

        if (!start) begin
            feat_d       = '{default: '0};
            best_class_d = '0;
            best_score_d = '0;
        end else begin
            if (cap_en) begin
                feat_d[cnt_q] = bus.f_in;
                cnt_d         = last_i ? '0 : cnt_q + 4'd1;
            end
            if (mac_en) begin
                cnt_d = last_i ? '0 : cnt_q + 4'd1;
                cls_d = last_i ? cls_q + CW'(1) : cls_q;
                // Strict compare so ties keep the lowest class index.
                if (last_i && ((cls_q == '0) || (mac_sum > best_score_q))) begin
                    best_class_d = 3'(cls_q);
                    best_score_d = mac_sum;
                end
            end
            if (state_q == StDone) begin
                c_valid_d = !(c_valid_q && bus.c_ready);
            end
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            f_finish_q   <= 1'b0;
            cnt_q        <= '0;
            cls_q        <= '0;
            feat_q       <= '{default: '0};
            w_q          <= '{default: '0};
            bias_q       <= '{default: '0};
            best_class_q <= '0;
            best_score_q <= '0;
            c_valid_q    <= 1'b0;
        end else begin
            f_finish_q   <= bus.f_finish;
            cnt_q        <= cnt_d;
            cls_q        <= cls_d;
            feat_q       <= feat_d;
            w_q          <= w_d;
            bias_q       <= bias_d;
            best_class_q <= best_class_d;
            best_score_q <= best_score_d;
            c_valid_q    <= c_valid_d;
        end
    end

    assign bus.w_busy  = w_busy;
    assign bus.c_valid = c_valid_q;
    assign bus.c_class = best_class_q;
    assign bus.c_score = best_score_q;

endmodule

// File: tb/tb_feature_classifier.sv
// Directed bench for feature_classifier: weight loading, argmax scoring, latency,
// handshake hold, synchronous clear via start, and writes dropped while busy.
module tb_feature_classifier;
    import feature_classifier_pkg::*;

    localparam int unsigned N         = 24;
    localparam int unsigned WW        = 16;
    localparam int unsigned NUM_CLASS = 3;
    localparam int unsigned ACC_W     = N + WW + 5;
    localparam int          Latency   = NF + NUM_CLASS * NF + 2;

    logic clk = 1'b0;
    logic nReset;
    logic start;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   edge_cnt     = 0;
    logic signed [N-1:0] feat_vec [NF];

    feature_classifier_if #(.N(N), .WW(WW), .ACC_W(ACC_W)) bus ();

    feature_classifier #(
        .N         (N),
        .WW        (WW),
        .NUM_CLASS (NUM_CLASS),
        .ACC_W     (ACC_W)
    ) dut (
        .clk    (clk),
        .nReset (nReset),
        .start  (start),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        edge_cnt++;
    endtask

    task automatic wr(input logic [7:0] addr, input longint data);
        bus.w_wr   = 1'b1;
        bus.w_addr = addr;
        bus.w_data = data[N+WW-1:0];
        tick();
        bus.w_wr   = 1'b0;
    endtask

    task automatic clear_feats();
        foreach (feat_vec[i]) feat_vec[i] = '0;
    endtask

    // Returns with all features sampled; edge_cnt counts edges from the rise-detect edge (0).
    task automatic start_burst();
        bus.f_finish = 1'b0;
        tick();
        bus.f_finish = 1'b1;
        edge_cnt     = -1;
        tick();
        tick();
        for (int k = 0; k < NF; k++) begin
            bus.f_in = feat_vec[k];
            tick();
        end
        bus.f_in = '0;
    endtask

    task automatic wait_result();
        for (int t = 0; t < 200 && !bus.c_valid; t++) tick();
        tests_run++;
        if (bus.c_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL wait_valid: c_valid=%b required 1 within 200 cycles", bus.c_valid);
        end
    endtask

    task automatic consume();
        bus.c_ready = 1'b1;
        tick();
        bus.c_ready  = 1'b0;
        bus.f_finish = 1'b0;
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        start  = 1'b1;
        bus.f_in = '0; bus.f_finish = 1'b0; bus.w_wr = 1'b0;
        bus.w_addr = '0; bus.w_data = '0; bus.c_ready = 1'b0;
        #22;
        nReset = 1'b1;
        tick();
        tests_run++;
        if ({bus.c_valid, bus.w_busy, bus.c_class} !== 5'b0 || bus.c_score !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: valid=%b busy=%b class=%0d score=%0d required all 0",
                     bus.c_valid, bus.w_busy, bus.c_class, $signed(bus.c_score));
        end
    endtask

    task automatic test_reset_mid_mac();
        wr(8'h0F, 11);
        wr(8'h00, 5);
        clear_feats();
        feat_vec[FRms] = 1;
        start_burst();
        repeat (5) tick();
        tests_run++;
        if (bus.w_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_mac_busy: w_busy=%b required 1", bus.w_busy);
        end
        bus.f_finish = 1'b0;
        #2 nReset = 1'b0;
        #2 nReset = 1'b1;
        tests_run++;
        if ({bus.c_valid, bus.w_busy, bus.c_class} !== 5'b0 || bus.c_score !== '0) begin
            tests_failed++;
            $display("FAIL mid_mac_reset: valid=%b busy=%b class=%0d score=%0d required all 0",
                     bus.c_valid, bus.w_busy, bus.c_class, $signed(bus.c_score));
        end
        start_burst();
        wait_result();
        tests_run++;
        if (bus.c_class !== 3'd0 || bus.c_score !== ACC_W'(0)) begin
            tests_failed++;
            $display("FAIL weights_cleared: class=%0d score=%0d required 0/0",
                     bus.c_class, $signed(bus.c_score));
        end
        consume();
    endtask

    task automatic test_bias_latency();
        wr(8'h2F, 5);
        clear_feats();
        feat_vec[FRms]    = 123;
        feat_vec[FMaxMag] = -7;
        start_burst();
        wait_result();
        tests_run++;
        if (edge_cnt != Latency) begin
            tests_failed++;
            $display("FAIL latency: c_valid after %0d edges required %0d", edge_cnt, Latency);
        end
        tests_run++;
        if (bus.c_class !== 3'd2 || bus.c_score !== ACC_W'(5)) begin
            tests_failed++;
            $display("FAIL bias_only: class=%0d score=%0d required 2/5",
                     bus.c_class, $signed(bus.c_score));
        end
        consume();
        tests_run++;
        if (bus.c_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL accept_drop: c_valid=%b required 0", bus.c_valid);
        end
    endtask

    task automatic test_weighted();
        wr(8'h2F, 0);
        wr(8'h10, 2);
        clear_feats();
        feat_vec[FRms] = 100;
        start_burst();
        wait_result();
        tests_run++;
        if (bus.c_class !== 3'd1 || bus.c_score !== ACC_W'(200)) begin
            tests_failed++;
            $display("FAIL weight_rms: class=%0d score=%0d required 1/200",
                     bus.c_class, $signed(bus.c_score));
        end
        consume();
        wr(8'h05, -1);
        wr(8'h3F, 1000);
        wr(8'h1A, 50);
        feat_vec[FSkew] = -300;
        start_burst();
        wait_result();
        tests_run++;
        if (bus.c_class !== 3'd0 || bus.c_score !== ACC_W'(300)) begin
            tests_failed++;
            $display("FAIL weight_skew: class=%0d score=%0d required 0/300",
                     bus.c_class, $signed(bus.c_score));
        end
        consume();
    endtask

    task automatic test_tie_hold();
        bit stable = 1'b1;
        wr(8'h10, 0);
        wr(8'h05, 0);
        wr(8'h0F, 7); wr(8'h1F, 7); wr(8'h2F, 7);
        clear_feats();
        feat_vec[FDisp] = 55;
        start_burst();
        wait_result();
        tests_run++;
        if (bus.c_class !== 3'd0 || bus.c_score !== ACC_W'(7)) begin
            tests_failed++;
            $display("FAIL tie_lowest: class=%0d score=%0d required 0/7",
                     bus.c_class, $signed(bus.c_score));
        end
        repeat (20) begin
            tick();
            if (bus.c_valid !== 1'b1 || bus.c_class !== 3'd0 || bus.c_score !== ACC_W'(7))
                stable = 1'b0;
        end
        tests_run++;
        if (!stable) begin
            tests_failed++;
            $display("FAIL hold_stable: outputs changed while c_ready=0 (now valid=%b class=%0d)",
                     bus.c_valid, bus.c_class);
        end
        consume();
        tests_run++;
        if (bus.c_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_release: c_valid=%b required 0", bus.c_valid);
        end
        wr(8'h0F, -5); wr(8'h1F, -3); wr(8'h2F, -9);
        start_burst();
        wait_result();
        tests_run++;
        if (bus.c_class !== 3'd1 || bus.c_score !== ACC_W'(-3)) begin
            tests_failed++;
            $display("FAIL negative_bias: class=%0d score=%0d required 1/-3",
                     bus.c_class, $signed(bus.c_score));
        end
        consume();
    endtask

    task automatic test_start_drop();
        bit seen = 1'b0;
        wr(8'h0F, 7); wr(8'h1F, 7); wr(8'h2F, 7);
        wr(8'h23, 4);
        clear_feats();
        feat_vec[FDisp] = 10;
        bus.f_finish = 1'b0;
        tick();
        bus.f_finish = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            bus.f_in = feat_vec[k];
            tick();
        end
        start    = 1'b0;
        bus.f_in = feat_vec[4];
        tick();
        repeat (60) begin
            tick();
            if (bus.c_valid) seen = 1'b1;
        end
        tests_run++;
        if (seen || bus.w_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_drop: c_valid seen=%b w_busy=%b required 0/0", seen, bus.w_busy);
        end
        start = 1'b1;
        start_burst();
        wait_result();
        tests_run++;
        if (bus.c_class !== 3'd2 || bus.c_score !== ACC_W'(47)) begin
            tests_failed++;
            $display("FAIL restart_burst: class=%0d score=%0d required 2/47",
                     bus.c_class, $signed(bus.c_score));
        end
        consume();
    endtask

    task automatic test_busy_write();
        wr(8'h0F, 0); wr(8'h1F, 0); wr(8'h2F, 0);
        wr(8'h23, 0);
        wr(8'h00, 1);
        clear_feats();
        feat_vec[FRms] = 50;
        start_burst();
        tests_run++;
        if (bus.w_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_flag: w_busy=%b required 1", bus.w_busy);
        end
        wr(8'h00, -10);
        wait_result();
        tests_run++;
        if (bus.c_class !== 3'd0 || bus.c_score !== ACC_W'(50)) begin
            tests_failed++;
            $display("FAIL busy_burst: class=%0d score=%0d required 0/50",
                     bus.c_class, $signed(bus.c_score));
        end
        consume();
        start_burst();
        wait_result();
        tests_run++;
        if (bus.c_class !== 3'd0 || bus.c_score !== ACC_W'(50)) begin
            tests_failed++;
            $display("FAIL busy_dropped: class=%0d score=%0d required 0/50",
                     bus.c_class, $signed(bus.c_score));
        end
        wr(8'h00, 3);
        consume();
        start_burst();
        wait_result();
        tests_run++;
        if (bus.c_class !== 3'd0 || bus.c_score !== ACC_W'(150)) begin
            tests_failed++;
            $display("FAIL done_write: class=%0d score=%0d required 0/150",
                     bus.c_class, $signed(bus.c_score));
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_reset_mid_mac();
        test_bias_latency();
        test_weighted();
        test_tie_hold();
        test_start_drop();
        test_busy_write();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
